// File: rtl/mode_sequencer_pkg.sv
// Shared definitions for the mode sequencer: FSM states, test-pattern mode
// codes and the bit layout of the mode_params byte.
package mode_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_DWELL  = 2'd1,
    ST_RESYNC = 2'd2
  } state_e;

  // Pattern codes carried in the mode field of mode_params.
  localparam logic [2:0] MODE_PASS = 3'd0;
  localparam logic [2:0] MODE_RAMP = 3'd1;
  localparam logic [2:0] MODE_BARS = 3'd2;
  localparam logic [2:0] MODE_XOR1 = 3'd4;
  localparam logic [2:0] MODE_XOR2 = 3'd5;
  localparam logic [2:0] MODE_XOR3 = 3'd6;

  // mode_params field positions: bit7 timing, [6:4] mode, [3:0] options.
  localparam int MP_TIMING_BIT = 7;
  localparam int MP_MODE_MSB   = 6;
  localparam int MP_MODE_LSB   = 4;
  localparam int MP_OPT_MSB    = 3;
  localparam int MP_OPT_LSB    = 0;

  // Power-on playlist contents: entry i selects mode i (truncated to 3 bits).
  function automatic logic [7:0] playlist_reset_value(input int idx);
    logic [7:0] v;
    v = '0;
    v[MP_MODE_MSB:MP_MODE_LSB] = 3'(idx);
    return v;
  endfunction

endpackage

// File: rtl/mode_sequencer_playlist.sv
// Playlist register file: one synchronous write port, one combinational
// read port. A read in the same cycle as a write returns the old contents.
module seq_playlist
  import mode_sequencer_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int IW        = $clog2(N_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [IW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] entries_q [N_ENTRIES];
  logic [7:0] entries_d [N_ENTRIES];

  // Next contents: unchanged except for the addressed entry on a write.
  always_comb begin
    // NOTE: every combinational output gets a full default first, so no path leaves it unassigned and no latch is inferred.
    entries_d = entries_q;
    if (wr_en) entries_d[wr_addr] = wr_data;
  end

  // Storage; every entry has a defined reset value so the playlist is usable straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this register file is small and needs known contents, so it is reset like ordinary flops; a large RAM would not be.
      for (int i = 0; i < N_ENTRIES; i++) entries_q[i] <= playlist_reset_value(i);
    end else begin
      entries_q <= entries_d;
    end
  end

  assign rd_data = entries_q[rd_addr];

endmodule

// File: rtl/mode_sequencer.sv
// Mode sequencer: picks the mode_params byte for the pattern controller,
// either from a manual input or by stepping through a playlist with a
// per-entry frame dwell, and holds the sync generator in reset for a few
// cycles whenever the timing bit changes.
module mode_sequencer
  import mode_sequencer_pkg::*;
#(
  parameter  int N_ENTRIES     = 8,
  parameter  int RESYNC_CYCLES = 4,
  localparam int IW            = $clog2(N_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          frame_end,
  input  logic          auto_en,
  input  logic [7:0]    manual_params,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_addr,
  input  logic [7:0]    cfg_data,
  input  logic [IW-1:0] last_idx,
  input  logic [7:0]    dwell,
  input  logic          skip,
  input  logic [7:0]    vstep,
  output logic [7:0]    mode_params,
  output logic [7:0]    voffset,
  output logic [IW-1:0] entry_idx,
  output logic          params_strobe,
  output logic          sync_reset
);

  localparam logic [7:0] RESYNC_LAST = 8'(RESYNC_CYCLES - 1);

  // ena low behaves exactly like reset, including the playlist contents.
  logic srst_n;
  assign srst_n = rst_n & ena;

  state_e        state_q, state_d;
  logic [7:0]    mp_q, mp_d;
  logic [7:0]    vo_q, vo_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          skip_q, skip_d;
  logic          strobe_q, strobe_d;
  logic          sync_q, sync_d;
  logic [7:0]    rcnt_q, rcnt_d;

  logic [IW-1:0] next_idx;
  logic [IW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    dwell_eff;
  logic [8:0]    cnt_plus;
  logic          expire;
  logic          load;
  logic [7:0]    load_val;

  seq_playlist #(.N_ENTRIES(N_ENTRIES), .IW(IW)) u_playlist (
    .clk     (clk),
    .rst_n   (srst_n),
    .wr_en   (cfg_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Playlist addressing and dwell-expiry detection.
  always_comb begin
    next_idx  = (idx_q >= last_idx) ? '0 : idx_q + 1'b1;
    rd_addr   = (state_q == ST_DWELL) ? next_idx : '0;
    dwell_eff = (dwell == 8'd0) ? 8'd1 : dwell;
    cnt_plus  = {1'b0, cnt_q} + 9'd1;
    expire    = cnt_plus >= {1'b0, dwell_eff};
  end

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_d  = state_q;
    mp_d     = mp_q;
    vo_d     = vo_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    skip_d   = skip_q | skip;
    strobe_d = 1'b0;
    sync_d   = 1'b0;
    rcnt_d   = rcnt_q;
    load     = 1'b0;
    load_val = rd_data;

    case (state_q)
      ST_MANUAL: begin
        vo_d = 8'd0;
        if (frame_end) begin
          skip_d = 1'b0;
          load   = 1'b1;
          if (auto_en) begin
            load_val = rd_data;
            idx_d    = '0;
            cnt_d    = 8'd0;
            state_d  = ST_DWELL;
          end else begin
            load_val = manual_params;
          end
        end
      end
      ST_DWELL: begin
        if (frame_end) begin
          skip_d = 1'b0;
          if (!auto_en) begin
            // Leaving playlist mode wins over any pending advance.
            load     = 1'b1;
            load_val = manual_params;
            vo_d     = 8'd0;
            cnt_d    = 8'd0;
            state_d  = ST_MANUAL;
          end else if (expire || skip_q || skip) begin
            load     = 1'b1;
            load_val = rd_data;
            idx_d    = next_idx;
            cnt_d    = 8'd0;
            vo_d     = 8'd0;
          end else begin
            cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
            vo_d  = vo_q + vstep;
          end
        end
      end
      ST_RESYNC: begin
        // frame_end is deliberately ignored while the sync generator is held.
        if (rcnt_q == RESYNC_LAST) begin
          state_d = auto_en ? ST_DWELL : ST_MANUAL;
        end else begin
          rcnt_d = rcnt_q + 8'd1;
          sync_d = 1'b1;
        end
      end
      default: state_d = ST_MANUAL;
    endcase

    if (load) begin
      mp_d     = load_val;
      strobe_d = (load_val != mp_q);
      if (load_val[MP_TIMING_BIT] != mp_q[MP_TIMING_BIT]) begin
        state_d = ST_RESYNC;
        rcnt_d  = 8'd0;
        sync_d  = 1'b1;
      end
    end
  end

  // All sequencer state and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q  <= ST_MANUAL;
      mp_q     <= 8'h00;
      vo_q     <= 8'd0;
      idx_q    <= '0;
      cnt_q    <= 8'd0;
      skip_q   <= 1'b0;
      strobe_q <= 1'b0;
      sync_q   <= 1'b0;
      rcnt_q   <= 8'd0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      mp_q     <= mp_d;
      vo_q     <= vo_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
      strobe_q <= strobe_d;
      sync_q   <= sync_d;
      rcnt_q   <= rcnt_d;
    end
  end

  assign mode_params   = mp_q;
  assign voffset       = vo_q;
  assign entry_idx     = idx_q;
  assign params_strobe = strobe_q;
  assign sync_reset    = sync_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Self-checking bench for mode_sequencer: a table of per-frame vectors for
// the playlist walk, then hand-written sequences for multi-cycle corners.
module tb_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, ena, frame_end, auto_en, cfg_we, skip;
  logic [7:0] manual_params, cfg_data, dwell, vstep;
  logic [2:0] cfg_addr, last_idx;
  logic [7:0] mode_params, voffset;
  logic [2:0] entry_idx;
  logic       params_strobe, sync_reset;

  int n_vec = 0;
  int n_err = 0;

  mode_sequencer #(.N_ENTRIES(8), .RESYNC_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .frame_end     (frame_end),
    .auto_en       (auto_en),
    .manual_params (manual_params),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .last_idx      (last_idx),
    .dwell         (dwell),
    .skip          (skip),
    .vstep         (vstep),
    .mode_params   (mode_params),
    .voffset       (voffset),
    .entry_idx     (entry_idx),
    .params_strobe (params_strobe),
    .sync_reset    (sync_reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       skip;
    logic       auto_en;
    logic [7:0] dwell;
    logic [7:0] vstep;
    logic [2:0] last_idx;
    logic [7:0] manual;
    logic [2:0] e_idx;
    logic [7:0] e_mp;
    logic [7:0] e_vo;
    logic       e_stb;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the frame_end edge.
  task automatic frame(input logic do_skip);
    if (do_skip) begin
      skip = 1'b1;
      @(negedge clk);
      skip = 1'b0;
    end
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic do_reset(input logic use_ena);
    frame_end = 1'b0; skip = 1'b0; cfg_we = 1'b0;
    if (use_ena) ena = 1'b0; else rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ena = 1'b1; rst_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " rst mode_params"}, 32'(mode_params), 32'h00);
    check({tag, " rst voffset"}, 32'(voffset), 32'h00);
    check({tag, " rst entry_idx"}, 32'(entry_idx), 32'h0);
    check({tag, " rst strobe"}, 32'(params_strobe), 32'h0);
    check({tag, " rst sync_reset"}, 32'(sync_reset), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hi;
    rst_n = 1'b0; ena = 1'b1; frame_end = 1'b0; auto_en = 1'b0; cfg_we = 1'b0;
    skip = 1'b0; manual_params = 8'h43; cfg_data = 8'h00; cfg_addr = 3'd0;
    dwell = 8'd2; vstep = 8'd3; last_idx = 3'd2;

    //            skip  auto dwell vstep last manual  idx  mp     vo    stb
    vecs[0]  = '{1'b0, 1'b1, 8'd2, 8'd3, 3'd2, 8'h43, 3'd0, 8'h00, 8'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'd2, 8'd3, 3'd2, 8'h43, 3'd0, 8'h00, 8'd3, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'd2, 8'd3, 3'd2, 8'h43, 3'd1, 8'h10, 8'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 8'd2, 8'd3, 3'd2, 8'h43, 3'd1, 8'h10, 8'd3, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'd2, 8'd3, 3'd2, 8'h43, 3'd2, 8'h20, 8'd0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'd2, 8'd3, 3'd2, 8'h43, 3'd2, 8'h20, 8'd3, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'd2, 8'd3, 3'd2, 8'h43, 3'd0, 8'h00, 8'd0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'd4, 8'd3, 3'd2, 8'h43, 3'd0, 8'h00, 8'd3, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'd4, 8'd3, 3'd2, 8'h43, 3'd0, 8'h00, 8'd6, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'd4, 8'd3, 3'd2, 8'h43, 3'd0, 8'h00, 8'd9, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'd4, 8'd3, 3'd2, 8'h43, 3'd1, 8'h10, 8'd0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 8'd2, 8'd3, 3'd2, 8'h43, 3'd2, 8'h20, 8'd0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 8'd2, 8'd3, 3'd2, 8'h43, 3'd2, 8'h20, 8'd3, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'd2, 8'd3, 3'd2, 8'h43, 3'd2, 8'h43, 8'd0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 8'd2, 8'd3, 3'd2, 8'h43, 3'd2, 8'h43, 8'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 8'd2, 8'd3, 3'd2, 8'h43, 3'd0, 8'h00, 8'd0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 8'd0, 8'd3, 3'd2, 8'h43, 3'd1, 8'h10, 8'd0, 1'b1};

    // Table-driven playlist walk.
    @(negedge clk);
    do_reset(1'b0);
    check_reset_state("tbl");
    for (int i = 0; i < 17; i++) begin
      auto_en = vecs[i].auto_en; dwell = vecs[i].dwell; vstep = vecs[i].vstep;
      last_idx = vecs[i].last_idx; manual_params = vecs[i].manual;
      frame(vecs[i].skip);
      check($sformatf("v%0d entry_idx", i), 32'(entry_idx), 32'(vecs[i].e_idx));
      check($sformatf("v%0d mode_params", i), 32'(mode_params), 32'(vecs[i].e_mp));
      check($sformatf("v%0d voffset", i), 32'(voffset), 32'(vecs[i].e_vo));
      check($sformatf("v%0d strobe", i), 32'(params_strobe), 32'(vecs[i].e_stb));
      @(negedge clk);
      check($sformatf("v%0d strobe_drop", i), 32'(params_strobe), 32'h0);
    end

    // Timing-bit change: 4-cycle sync_reset, frame_end ignored meanwhile.
    do_reset(1'b0);
    auto_en = 1'b1; dwell = 8'd1; last_idx = 3'd1; vstep = 8'd0;
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'h80;
    @(negedge clk);
    cfg_we = 1'b0;
    frame(1'b0);
    check("rs first mode_params", 32'(mode_params), 32'h00);
    check("rs first sync_reset", 32'(sync_reset), 32'h0);
    frame(1'b0);
    check("rs load mode_params", 32'(mode_params), 32'h80);
    check("rs load entry_idx", 32'(entry_idx), 32'h1);
    check("rs load strobe", 32'(params_strobe), 32'h1);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (sync_reset) hi++;
      frame_end = (i < 3);
      @(negedge clk);
    end
    frame_end = 1'b0;
    check("rs sync_reset cycles", 32'(hi), 32'd4);
    check("rs ignored entry_idx", 32'(entry_idx), 32'h1);
    check("rs ignored mode_params", 32'(mode_params), 32'h80);
    // Reset in the middle of a second resync drops sync_reset next cycle.
    frame(1'b0);
    check("rs2 mode_params", 32'(mode_params), 32'h00);
    check("rs2 sync_reset", 32'(sync_reset), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rs2 reset sync_reset", 32'(sync_reset), 32'h0);
    rst_n = 1'b1;

    // Skip and dwell expiry in one frame: a single advance; shrinking last_idx.
    do_reset(1'b1);
    check_reset_state("ena");
    auto_en = 1'b1; dwell = 8'd2; last_idx = 3'd2; vstep = 8'd1;
    frame(1'b0);
    frame(1'b0);
    check("sk before entry_idx", 32'(entry_idx), 32'h0);
    frame(1'b1);
    check("sk advance entry_idx", 32'(entry_idx), 32'h1);
    frame(1'b0);
    check("sk cleared entry_idx", 32'(entry_idx), 32'h1);
    last_idx = 3'd0;
    frame(1'b0);
    check("shrink entry_idx", 32'(entry_idx), 32'h0);
    check("shrink mode_params", 32'(mode_params), 32'h00);

    // Write and advance to the same entry together: old value loads first.
    do_reset(1'b0);
    auto_en = 1'b1; dwell = 8'd1; last_idx = 3'd1;
    frame(1'b0);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'h5A;
    frame(1'b0);
    cfg_we = 1'b0;
    check("wr same entry_idx", 32'(entry_idx), 32'h1);
    check("wr same mode_params", 32'(mode_params), 32'h10);
    frame(1'b0);
    check("wr wrap mode_params", 32'(mode_params), 32'h00);
    frame(1'b0);
    check("wr later mode_params", 32'(mode_params), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 8, playlist depth (power of two, index width IW = log2(N_ENTRIES)).
REQ-002 SHALL have parameter RESYNC_CYCLES, default 4, length of the sync_reset pulse on a timing-mode change.
REQ-003 SHALL have clk input 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have rst_n input 1, reset that is synchronous and active-low.
REQ-005 SHALL have ena input 1; ena low is treated exactly as rst_n low.
REQ-006 SHALL have frame_end input 1, a one-cycle pulse at the last pixel of each frame (hmax AND vmax).
REQ-007 SHALL have auto_en input 1; 1 = playlist mode, 0 = manual mode.
REQ-008 SHALL have manual_params input 8, the mode_params byte used in manual mode.
REQ-009 SHALL have cfg_we input 1, cfg_addr input IW and cfg_data input 8, the playlist write port.
REQ-010 SHALL have last_idx input IW, the highest playlist index in use.
REQ-011 SHALL have dwell input 8, frames per entry (0 treated as 1).
REQ-012 SHALL have skip input 1, a one-cycle request to advance at the next frame_end.
REQ-013 SHALL have vstep input 8, the voffset increment per frame (unsigned, mod 256).
REQ-014 SHALL have mode_params output 8, the registered byte driving the controller (bit7 timing, [6:4] mode, [3:0] options).
REQ-015 SHALL have voffset output 8, the registered vertical offset.
REQ-016 SHALL have entry_idx output IW, the active playlist index.
REQ-017 SHALL have params_strobe output 1, a one-cycle pulse whenever mode_params changes.
REQ-018 SHALL have sync_reset output 1; when high, the sync generator is held in reset.

Function
REQ-019 FSM states SHALL be MANUAL, DWELL, RESYNC.
REQ-020 Playlist SHALL be N_ENTRIES x 8 registers; a write occurs when cfg_we=1, in any state.
REQ-021 In MANUAL, mode_params SHALL load manual_params on each frame_end; voffset SHALL hold 0.
REQ-022 In MANUAL, frame_end with auto_en=1 SHALL load entry[0], set entry_idx=0 and dwell count=0, and go to DWELL (or to RESYNC if bit7 changes).
REQ-023 In DWELL, each frame_end SHALL increment the dwell count and add vstep to voffset.
REQ-024 In DWELL, an advance SHALL occur at the frame_end where count+1 >= max(dwell,1), or where skip was latched since the previous frame_end.
REQ-025 Dwell expiry and skip in the same frame SHALL produce exactly one advance.
REQ-026 On advance, entry_idx SHALL become 0 if entry_idx >= last_idx, else entry_idx+1; mode_params SHALL load the new entry, dwell count and voffset SHALL clear to 0, and the skip latch SHALL clear.
REQ-027 A cfg write and an advance reading the same entry in the same cycle SHALL load the pre-write value.
REQ-028 last_idx reduced below entry_idx SHALL wrap to 0 at the next advance.
REQ-029 In DWELL, frame_end with auto_en=0 SHALL go to MANUAL and load manual_params, taking priority over any advance.
REQ-030 Any mode_params load whose bit7 differs from the previous value SHALL enter RESYNC.
REQ-031 RESYNC SHALL assert sync_reset for exactly RESYNC_CYCLES cycles starting the cycle after the load, then return to DWELL or MANUAL per auto_en; frame_end is ignored while in RESYNC.
REQ-032 params_strobe SHALL be high in the cycle after a load only if the value changed; mode_params, voffset and entry_idx update with 1-cycle latency from frame_end.
REQ-033 The dwell count SHALL be 8 bits and saturate at 255.

Reset
REQ-034 While rst_n=0 or ena=0: state=MANUAL, mode_params=0x00, voffset=0, entry_idx=0, dwell count=0, skip latch=0, params_strobe=0, sync_reset=0.
REQ-035 Playlist entry i SHALL reset to {1'b0, i[2:0], 4'b0000} (index i, truncated to 3 bits, in the mode field).
REQ-036 Reset asserted mid-RESYNC SHALL drop sync_reset in the next cycle.

Structure
REQ-037 A shared package SHALL hold the state enum, the MODE_* codes (PASS=0, RAMP=1, BARS=2, XOR1=4, XOR2=5, XOR3=6) and the mode_params field positions.
REQ-038 One sub-module, seq_playlist (register file, one write port, one combinational read port), SHALL be used.

Verification
REQ-039 Scenario: reset, auto_en=1, last_idx=2, dwell=2, 7 frame_end -> entry_idx 0,0,1,1,2,2,0 after each pulse; mode_params 0x00,0x00,0x10,0x10,0x20,0x20,0x00.
REQ-040 Scenario: vstep=3, dwell=4 -> voffset 3,6,9, then 0 at the advance.
REQ-041 Scenario: entry1=0x80 with entry0=0x00 -> sync_reset high for exactly 4 cycles after the load; frame_end during those cycles is ignored.
REQ-042 Scenario: skip pulse plus dwell expiry in the same frame -> one advance (idx 0->1, not 2).
REQ-043 Scenario: cfg write to entry1=0x5A in the same cycle as the advance to 1 -> mode_params=0x10; a later return to entry1 -> 0x5A.
REQ-044 Scenario: auto_en=0 mid-dwell, manual_params=0x43 -> next frame_end gives mode_params=0x43, voffset=0, params_strobe high for one cycle.
